// File: rtl/nota_uart_framer.sv
// Sends each new note code as a 4-byte checksummed 8N1 UART frame:
// header, code byte, sequence and XOR. Also resends on keepalive, keeps one pending code and counts drops.
module nota_uart_framer #(
  parameter int unsigned CLK_FREQ         = 25_000_000,
  parameter int unsigned BAUD_RATE        = 115200,
  parameter int unsigned KEEPALIVE_CYCLES = 25_000_000,
  parameter logic [7:0]  HEADER           = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  codigo,
  input  logic        codigo_valid,
  output logic        uart_tx,
  output logic        busy,
  output logic [15:0] frames_sent,
  output logic [7:0]  drop_count
);

  localparam int unsigned BIT_TIME = CLK_FREQ / BAUD_RATE;
  localparam int TW = $clog2(BIT_TIME + 1);
  localparam int KW = $clog2(KEEPALIVE_CYCLES + 1);
  localparam logic [TW-1:0] BIT_LAST = TW'(BIT_TIME - 1);
  localparam logic [KW-1:0] KA_LAST  = KW'(KEEPALIVE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  function automatic logic [7:0] code_byte(input logic [2:0] code);
    logic [7:0] b;
    case (code)
      3'd2:    b = 8'h00;
      3'd3:    b = 8'h02;
      3'd4:    b = 8'h04;
      default: b = 8'h80;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] xor_sum(input logic [23:0] body);
    return body[7:0] ^ body[15:8] ^ body[23:16];
  endfunction

  // Byte 0 sits in the low bits so the byte index selects it directly.
  function automatic logic [31:0] build_frame(input logic [2:0] code, input logic [7:0] seq);
    logic [23:0] body;
    body = {seq, code_byte(code), HEADER};
    return {xor_sum(body), body};
  endfunction

  state_t         state_r, state_n;
  logic [TW-1:0]  timer_r, timer_n;
  logic [1:0]     byte_r, byte_n;
  logic [2:0]     bit_r, bit_n;
  logic           tx_r, tx_n;
  logic           busy_r, busy_n;
  logic [31:0]    frame_r;
  logic [7:0]     seq_r;
  logic [2:0]     last_code_r;
  logic           last_v_r;
  logic [2:0]     pend_code_r;
  logic           pend_v_r;
  logic [KW-1:0]  ka_r;
  logic [15:0]    frames_r;
  logic [7:0]     drop_r;

  logic           new_code_s;
  logic           ka_exp_s;
  logic           bit_end_s;
  logic           chain_s;
  logic           start_s;
  logic           done_s;
  logic [2:0]     start_code_s;
  logic [7:0]     cur_byte_s;
  logic [2:0]     next_bit_s;

  assign new_code_s = codigo_valid && (!last_v_r || (codigo != last_code_r));
  assign ka_exp_s   = last_v_r && (ka_r == KA_LAST);
  assign bit_end_s  = (timer_r == BIT_LAST);
  assign chain_s    = new_code_s || (pend_v_r && (pend_code_r != last_code_r));
  assign cur_byte_s = frame_r[{byte_r, 3'b000} +: 8];
  assign next_bit_s = bit_r + 3'd1;

  // Next-state, bit timing and next line level for the serializer.
  always_comb begin
    state_n      = state_r;
    timer_n      = timer_r + TW'(1);
    byte_n       = byte_r;
    bit_n        = bit_r;
    tx_n         = tx_r;
    busy_n       = busy_r;
    start_s      = 1'b0;
    done_s       = 1'b0;
    start_code_s = last_code_r;
    case (state_r)
      IDLE: begin
        timer_n = TW'(0);
        tx_n    = 1'b1;
        busy_n  = 1'b0;
        if (new_code_s || ka_exp_s) begin
          start_s      = 1'b1;
          start_code_s = new_code_s ? codigo : last_code_r;
          state_n      = START;
          tx_n         = 1'b0;
          busy_n       = 1'b1;
          byte_n       = 2'd0;
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_n = DATA;
          timer_n = TW'(0);
          bit_n   = 3'd0;
          tx_n    = cur_byte_s[0];
        end else begin
          state_n = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          timer_n = TW'(0);
          if (bit_r == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n = next_bit_s;
            tx_n  = cur_byte_s[next_bit_s];
          end
        end else begin
          state_n = DATA;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          timer_n = TW'(0);
          if (byte_r != 2'd3) begin
            byte_n  = byte_r + 2'd1;
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            done_s = 1'b1;
            // A strobe landing on the final stop cycle wins over the older pending code.
            if (chain_s) begin
              start_s      = 1'b1;
              start_code_s = new_code_s ? codigo : pend_code_r;
              state_n      = START;
              tx_n         = 1'b0;
              byte_n       = 2'd0;
            end else begin
              state_n = IDLE;
              tx_n    = 1'b1;
              busy_n  = 1'b0;
            end
          end
        end else begin
          state_n = STOP;
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = TW'(0);
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  // Serializer state and registered line outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      timer_r <= TW'(0);
      byte_r  <= 2'd0;
      bit_r   <= 3'd0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      timer_r <= timer_n;
      byte_r  <= byte_n;
      bit_r   <= bit_n;
      tx_r    <= tx_n;
      busy_r  <= busy_n;
    end
  end

  // Frame contents, sequence, last code and keepalive timer, all refreshed at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_r     <= 32'h0000_0000;
      seq_r       <= 8'd0;
      last_code_r <= 3'd0;
      last_v_r    <= 1'b0;
      ka_r        <= KW'(0);
    end else if (start_s) begin
      frame_r     <= build_frame(start_code_s, seq_r);
      seq_r       <= seq_r + 8'd1;
      last_code_r <= start_code_s;
      last_v_r    <= 1'b1;
      ka_r        <= KW'(0);
    end else if (last_v_r && (ka_r != KA_LAST)) begin
      ka_r <= ka_r + KW'(1);
    end
  end

  // One-deep pending slot, drop and frame counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_code_r <= 3'd0;
      pend_v_r    <= 1'b0;
      drop_r      <= 8'd0;
      frames_r    <= 16'd0;
    end else begin
      if (start_s) begin
        pend_v_r <= 1'b0;
      end else if ((state_r != IDLE) && new_code_s) begin
        pend_v_r    <= 1'b1;
        pend_code_r <= codigo;
      end
      if ((state_r != IDLE) && new_code_s && pend_v_r && (drop_r != 8'hFF)) begin
        drop_r <= drop_r + 8'd1;
      end
      if (done_s) begin
        frames_r <= frames_r + 16'd1;
      end
    end
  end

  assign uart_tx     = tx_r;
  assign busy        = busy_r;
  assign frames_sent = frames_r;
  assign drop_count  = drop_r;

endmodule

// File: doc/nota_uart_framer.md
# nota_uart_framer

Downstream stage of the edge-counter/note path: takes the 3-bit note code produced once per measurement window and transmits it over UART as a 4-byte checksummed frame. It replaces free-running byte streaming. Frames are sent only on a code change or a keepalive timeout. It contains its own 8N1 serializer with a busy indication, a one-deep pending slot and drop accounting.

## Interface
- `CLK_FREQ`, 25_000_000, clock frequency in Hz
- `BAUD_RATE`, 115200, line rate; `BIT_TIME = CLK_FREQ / BAUD_RATE` (integer division, 217 at defaults)
- `KEEPALIVE_CYCLES`, 25_000_000, resend period for an unchanged code; must exceed `40*BIT_TIME`
- `HEADER`, 8'hA5, first byte of every frame
- `clk`  in  1  single system clock, all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `codigo`  in  3  note code from the edge counter (2, 3, 4 valid; others flagged)
- `codigo_valid`  in  1  one-cycle strobe, `codigo` sampled when high
- `uart_tx`  out  1  serial line, idle high
- `busy`  out  1  high while a frame is on the line
- `frames_sent`  out  16  completed frames, wraps
- `drop_count`  out  8  overwritten pending codes, saturates at 255

## Operation
- Reset values:
  - `uart_tx`=1, `busy`=0, `frames_sent`=0, `drop_count`=0.
  - Internal `seq`=0, `last_code` invalid, pending empty, keepalive timer stopped.
- Frame layout: byte0=`HEADER`, byte1={invalid, 4'b0, nota}, byte2=`seq`, byte3=XOR of bytes 0..2.
- Code mapping:
  - 2→nota 0, 3→nota 2, 4→nota 4.
  - Any other code→nota 0 with invalid=1.
- Bytes are sent 8N1, LSB first: start bit 0, 8 data bits, stop bit 1. The 4 bytes go back-to-back with no idle between them.
- FSM states: IDLE, START, DATA, STOP. A byte index 0..3 and bit index 0..7 track progress. Each state holds `uart_tx` for exactly `BIT_TIME` cycles.
  - IDLE→START on a trigger; the frame bytes are latched at this transition.
  - START→DATA→STOP per byte.
  - STOP→START with the next byte index if byte index < 3.
  - After byte 3's STOP: go to START if pending holds a code ≠ `last_code`, otherwise go to IDLE.
- Triggers in IDLE:
  - (a) `codigo_valid` with `codigo`≠`last_code`, or any code while `last_code` is invalid (first frame after reset).
  - (b) Keepalive expiry, which resends `last_code`.
  - If both occur in the same cycle, exactly one frame is sent, using the new code.
- At every frame start:
  - `last_code` is set to the frame's code.
  - `seq` increments after latching (first frame uses seq 0; 255 wraps to 0).
  - The keepalive timer restarts.
- While busy:
  - A `codigo_valid` with `codigo`≠`last_code` is written into pending.
  - If pending is already full, the new code overwrites it and `drop_count` increments (saturating).
  - A `codigo_valid` equal to `last_code` is ignored.
- Keepalive: the timer runs only after the first frame. Its frame starts exactly `KEEPALIVE_CYCLES` cycles after the previous frame start, unless another frame started first.
- `frames_sent` increments on the last cycle of byte 3's stop bit.
- Reset mid-frame:
  - `uart_tx` goes to 1 and `busy` goes to 0 immediately (asynchronously).
  - The frame is aborted; `seq`, pending and `last_code` are cleared.

## Timing
- Start latency: `codigo_valid` sampled high in IDLE → `uart_tx` low and `busy` high on the next rising edge (1 cycle).
- Frame duration: `40*BIT_TIME` cycles (8680 at defaults).
- `busy` deasserts on the edge after byte 3's stop bit completes. In the same cycle `uart_tx` stays 1.
- Pending frame: its start bit begins on the edge where the previous stop bit ends. `busy` stays high continuously, with no idle gap.
- `drop_count` and pending updates are visible 1 cycle after the strobe.

## Test plan
- Use `BIT_TIME`=217 and `KEEPALIVE_CYCLES`=20000 unless stated.
- Reset, then `codigo`=3 strobe:
  - Bytes A5 02 00 A7; start bit 1 cycle after the strobe.
  - `busy` high for 8680 cycles; `frames_sent`=1.
- After the first frame, strobe `codigo`=3 again:
  - No frame is sent.
  - 20000 cycles after the first frame's start, the frame A5 02 01 A6 goes out.
- During the first frame (`codigo`=3), strobe 4 then 2:
  - `drop_count`=1.
  - The second frame A5 00 01 A4 follows back-to-back; `busy` never drops between the frames.
- Reset, then `codigo`=7: frame A5 80 00 25.
- Assert `rst_n` low mid-data bit of byte 1:
  - `uart_tx`=1 and `busy`=0 without waiting for a clock.
  - After release, `codigo`=4 gives A5 04 00 A1 (seq restarted).
- Check bit timing: every bit boundary is exactly 217 cycles apart. Simultaneous keepalive expiry and a new-code strobe produce one frame carrying the new code.
